// File: rtl/ldm_writeback_seq.sv
// LDM micro-sequencer: walks the latched register list lowest-first, issues one
// data read per register and streams returned words to the register file / PC.
module ldm_writeback_seq #(
    parameter int unsigned MEM_LAT = 1  // only a one-cycle read latency is supported
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    input  logic [3:0]  rn,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    output logic        busy,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pc_we,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_LAST,
        S_BASEWB
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        reglist_q, reglist_d;
    logic [15:0]        list_q, list_d;
    logic [31:0]        base_q, base_d;
    logic [3:0]         rn_q, rn_d;
    logic               up_q, up_d;
    logic               pre_q, pre_d;
    logic               wback_q, wback_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wb_val_q, wb_val_d;
    logic [MEM_LAT-1:0] wr_vld_q, wr_vld_d;
    logic [3:0]         wr_idx_q, wr_idx_d;

    logic [4:0]  n_regs;
    logic [31:0] four_n;
    logic [3:0]  low_idx;
    logic [15:0] list_clr;

    always_comb begin
        n_regs = '0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + 5'(reglist_q[i]);
        end
        four_n = {25'd0, n_regs, 2'b00};

        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) low_idx = 4'(i);
        end
        // x & (x-1) drops the lowest set bit, i.e. the register being issued now.
        list_clr = list_q & (list_q - 16'd1);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        reglist_d = reglist_q;
        list_d    = list_q;
        base_d    = base_q;
        rn_d      = rn_q;
        up_d      = up_q;
        pre_d     = pre_q;
        wback_d   = wback_q;
        addr_d    = addr_q;
        wb_val_d  = wb_val_q;
        wr_vld_d  = '0;
        wr_idx_d  = wr_idx_q;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = start;
                if (start) begin
                    reglist_d = reglist;
                    list_d    = reglist;
                    base_d    = base;
                    rn_d      = rn;
                    up_d      = up;
                    pre_d     = pre;
                    wback_d   = wback;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                busy = 1'b1;
                // The lowest address is always read first, whichever direction.
                if (up_q) addr_d = pre_q ? base_q + 32'd4 : base_q;
                else      addr_d = pre_q ? base_q - four_n : base_q - four_n + 32'd4;
                wb_val_d = up_q ? base_q + four_n : base_q - four_n;
                if (n_regs == 5'd0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                busy        = 1'b1;
                mem_re      = 1'b1;
                mem_addr    = addr_q;
                addr_d      = addr_q + 32'd4;
                list_d      = list_clr;
                wr_vld_d[0] = 1'b1;
                wr_idx_d    = low_idx;
                if (list_clr == 16'd0) state_d = S_LAST;
            end
            S_LAST: begin
                busy = 1'b1;
                // A base register that is also loaded keeps the loaded value.
                if (wback_q && !reglist_q[rn_q]) begin
                    state_d = S_BASEWB;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BASEWB: begin
                busy    = 1'b1;
                rf_we   = 1'b1;
                rf_wa   = rn_q;
                rf_wd   = wb_val_q;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_vld_q[MEM_LAT-1]) begin
            rf_wa = wr_idx_q;
            rf_wd = mem_rdata;
            rf_we = (wr_idx_q != 4'd15);
            pc_we = (wr_idx_q == 4'd15);
        end
    end

    // NOTE: non-blocking assignments only in clocked logic, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_vld_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_vld_q <= wr_vld_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are only observed once the FSM has loaded them.
    always_ff @(posedge clk) begin
        reglist_q <= reglist_d;
        list_q    <= list_d;
        base_q    <= base_d;
        rn_q      <= rn_d;
        up_q      <= up_d;
        pre_q     <= pre_d;
        wback_q   <= wback_d;
        addr_q    <= addr_d;
        wb_val_q  <= wb_val_d;
        wr_idx_q  <= wr_idx_d;
    end

endmodule

// File: tb/tb_ldm_writeback_seq.sv
// Randomized bench for ldm_writeback_seq: a per-cycle expected trace is derived
// from the LDM timing rules and compared at every falling edge.
module tb_ldm_writeback_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] reglist;
    logic [31:0] base;
    logic [3:0]  rn;
    logic        up;
    logic        pre;
    logic        wback;
    logic        busy;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic        done;

    int checks   = 0;
    int failures = 0;

    ldm_writeback_seq #(.MEM_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .reglist   (reglist),
        .base      (base),
        .rn        (rn),
        .up        (up),
        .pre       (pre),
        .wback     (wback),
        .busy      (busy),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pc_we     (pc_we),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] reglist;
        logic [31:0] base;
        logic [3:0]  rn;
        logic        up;
        logic        pre;
        logic        wback;
    } req_t;

    typedef struct packed {
        logic        busy;
        logic        mem_re;
        logic [31:0] mem_addr;
        logic        rf_we;
        logic [3:0]  rf_wa;
        logic [31:0] rf_wd;
        logic        pc_we;
        logic        done;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [31:0] mem_ov [logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory: answers a read seen in one cycle with data during the next cycle.
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = '0;
    always @(negedge clk) begin
        rd_pend = mem_re;
        rd_addr = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_rdata = rd_pend ? mem_val(rd_addr) : 32'hDEAD_BEEF;
    end

    // Expected per-cycle trace, cycle 0 being the start cycle.
    task automatic model(input req_t r);
        int          regs[$];
        int          n;
        int          len;
        bit          do_wb;
        logic [31:0] a0;
        logic [31:0] wbv;
        logic [31:0] a;
        cyc_t        tr [24];
        exp_q.delete();
        for (int i = 0; i < 16; i++) if (r.reglist[i]) regs.push_back(i);
        n     = regs.size();
        a0    = r.up ? r.base + (r.pre ? 32'd4 : 32'd0)
                     : r.base - 32'(4 * n) + (r.pre ? 32'd0 : 32'd4);
        wbv   = r.up ? r.base + 32'(4 * n) : r.base - 32'(4 * n);
        do_wb = r.wback && !r.reglist[r.rn] && (n != 0);
        len   = (n == 0) ? 2 : n + 3 + (do_wb ? 1 : 0);
        for (int c = 0; c < 24; c++) begin
            tr[c]      = '0;
            tr[c].busy = (c < len);
        end
        if (n == 0) begin
            tr[1].done = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) begin
                a                  = a0 + 32'(4 * k);
                tr[k + 2].mem_re   = 1'b1;
                tr[k + 2].mem_addr = a;
                tr[k + 3].rf_we    = (regs[k] != 15);
                tr[k + 3].pc_we    = (regs[k] == 15);
                tr[k + 3].rf_wa    = 4'(regs[k]);
                tr[k + 3].rf_wd    = mem_val(a);
            end
            if (do_wb) begin
                tr[n + 3].rf_we = 1'b1;
                tr[n + 3].rf_wa = r.rn;
                tr[n + 3].rf_wd = wbv;
                tr[n + 3].done  = 1'b1;
            end else begin
                tr[n + 2].done = 1'b1;
            end
        end
        for (int c = 0; c < len; c++) exp_q.push_back(tr[c]);
    endtask

    task automatic scramble_inputs();
        reglist = 16'($urandom);
        base    = $urandom;
        rn      = 4'($urandom);
        up      = 1'($urandom);
        pre     = 1'($urandom);
        wback   = 1'($urandom);
    endtask

    // Entered and left just after a rising edge. With hold=1, start stays high
    // through the transfer and the done cycle; the caller must start the next one.
    task automatic run_ldm(input string tag, input req_t r, input bit hold);
        cyc_t e;
        model(r);
        {reglist, base, rn, up, pre, wback} = r;
        start = 1'b1;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            e = exp_q[c];
            checks++;
            if ({busy, mem_re, rf_we, pc_we, done} !== {e.busy, e.mem_re, e.rf_we, e.pc_we, e.done}) begin
                failures++;
                $display("FAIL %s cyc%0d busy/re/we/pc/done got %b expected %b", tag, c,
                         {busy, mem_re, rf_we, pc_we, done}, {e.busy, e.mem_re, e.rf_we, e.pc_we, e.done});
            end
            if (e.mem_re) begin
                checks++;
                if (mem_addr !== e.mem_addr) begin
                    failures++;
                    $display("FAIL %s cyc%0d mem_addr got %h expected %h", tag, c, mem_addr, e.mem_addr);
                end
            end
            if (e.rf_we || e.pc_we) begin
                checks++;
                if ({rf_wa, rf_wd} !== {e.rf_wa, e.rf_wd}) begin
                    failures++;
                    $display("FAIL %s cyc%0d write got r%0d=%h expected r%0d=%h", tag, c,
                             rf_wa, rf_wd, e.rf_wa, e.rf_wd);
                end
            end
            @(posedge clk);
            #1;
            if (c < exp_q.size() - 1) begin
                start = hold;
                scramble_inputs();
            end
        end
    endtask

    task automatic idle_cycles(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, mem_re, rf_we, pc_we, done} !== 5'b0) begin
                failures++;
                $display("FAIL %s idle%0d busy/re/we/pc/done got %b expected 00000", tag, c,
                         {busy, mem_re, rf_we, pc_we, done});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        {reglist, base, rn, up, pre, wback} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_addr, rf_we, rf_wa, rf_wd, pc_we, done} !== '0) begin
            failures++;
            $display("FAIL reset outputs got busy=%b re=%b addr=%h we=%b wa=%h wd=%h pc=%b done=%b expected all 0",
                     busy, mem_re, mem_addr, rf_we, rf_wa, rf_wd, pc_we, done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles("post_reset", 2);
    endtask

    task automatic test_ia_wback();
        mem_ov[32'h100] = 32'hA1;
        mem_ov[32'h104] = 32'hB2;
        run_ldm("ia_wback", '{reglist: 16'h0006, base: 32'h100, rn: 4'd0, up: 1'b1, pre: 1'b0, wback: 1'b1}, 1'b0);
        idle_cycles("ia_wback_after", 1);
    endtask

    task automatic test_db_pc();
        run_ldm("db_pc", '{reglist: 16'h8001, base: 32'h200, rn: 4'd5, up: 1'b0, pre: 1'b1, wback: 1'b0}, 1'b0);
        idle_cycles("db_pc_after", 1);
    endtask

    task automatic test_empty();
        run_ldm("empty", '{reglist: 16'h0000, base: 32'h80, rn: 4'd2, up: 1'b1, pre: 1'b0, wback: 1'b1}, 1'b0);
        idle_cycles("empty_after", 3);
    endtask

    task automatic test_base_conflict();
        run_ldm("conflict", '{reglist: 16'h0008, base: 32'h40, rn: 4'd3, up: 1'b1, pre: 1'b0, wback: 1'b1}, 1'b0);
        idle_cycles("conflict_after", 1);
    endtask

    task automatic test_wrap();
        run_ldm("wrap_db", '{reglist: 16'h0007, base: 32'h4, rn: 4'd9, up: 1'b0, pre: 1'b1, wback: 1'b1}, 1'b0);
        run_ldm("wrap_ia", '{reglist: 16'hF000, base: 32'hFFFF_FFF8, rn: 4'd1, up: 1'b1, pre: 1'b0, wback: 1'b1}, 1'b0);
        idle_cycles("wrap_after", 1);
    endtask

    task automatic test_reset_mid();
        req_t r;
        cyc_t e;
        r = '{reglist: 16'h00F0, base: 32'h300, rn: 4'd1, up: 1'b1, pre: 1'b0, wback: 1'b1};
        model(r);
        {reglist, base, rn, up, pre, wback} = r;
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = exp_q[c];
            checks++;
            if ({busy, mem_re, rf_we, pc_we} !== {e.busy, e.mem_re, e.rf_we, e.pc_we}) begin
                failures++;
                $display("FAIL reset_mid cyc%0d busy/re/we/pc got %b expected %b", c,
                         {busy, mem_re, rf_we, pc_we}, {e.busy, e.mem_re, e.rf_we, e.pc_we});
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            reset = (c == 2);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_addr, rf_we, rf_wa, rf_wd, pc_we, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid outputs got busy=%b re=%b addr=%h we=%b wa=%h wd=%h pc=%b done=%b expected all 0",
                     busy, mem_re, mem_addr, rf_we, rf_wa, rf_wd, pc_we, done);
        end
        @(posedge clk);
        #1;
        idle_cycles("reset_mid_quiet", 5);
        scramble_inputs();
        run_ldm("reset_mid_restart", {reglist, base, rn, up, pre, wback}, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_ldm("b2b_first", '{reglist: 16'h0421, base: 32'h1000, rn: 4'd7, up: 1'b1, pre: 1'b1, wback: 1'b1}, 1'b1);
        run_ldm("b2b_second", '{reglist: 16'h8102, base: 32'h2000, rn: 4'd4, up: 1'b0, pre: 1'b0, wback: 1'b1}, 1'b0);
        idle_cycles("b2b_after", 4);
    endtask

    task automatic test_random();
        req_t r;
        bit   hold;
        for (int i = 0; i < 40; i++) begin
            r.base  = $urandom;
            r.rn    = 4'($urandom);
            r.up    = 1'($urandom);
            r.pre   = 1'($urandom);
            r.wback = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       r.reglist = 16'h0000;
                1:       r.reglist = 16'hFFFF;
                2:       r.reglist = 16'h0001 << $urandom_range(0, 15);
                default: r.reglist = 16'($urandom);
            endcase
            hold = (i < 39) ? 1'($urandom) : 1'b0;
            run_ldm($sformatf("rand%0d", i), r, hold);
        end
        idle_cycles("rand_after", 2);
    endtask

    initial begin
        mem_rdata = '0;
        test_reset();
        test_ia_wback();
        test_db_pc();
        test_empty();
        test_base_conflict();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldm_writeback_seq.md
Name: ldm_writeback_seq

Overview:
- Multi-cycle load-multiple (LDM) micro-sequencer for the five-stage ARM pipeline.
- Accepts one LDM request from the execute stage and walks the 16-bit register list, lowest index first.
- Issues one data-memory read per selected register and drives the register-file write port (write enable, write address, write data) with each returned word.
- Stalls the pipeline while active; redirects r15 loads to the PC-load path; optionally writes back the updated base.

Parameters:
MEM_LAT, 1, data-memory read latency in cycles from mem_re to valid mem_rdata; only 1 is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; honoured only in IDLE
reglist  input  16  bit i set = load register i
base  input  32  base address (value of Rn)
rn  input  4  base register index
up  input  1  1 = increment, 0 = decrement
pre  input  1  1 = before (IB/DB), 0 = after (IA/DA)
wback  input  1  write updated base to rn
busy  output  1  pipeline stall request
mem_re  output  1  data-memory read enable
mem_addr  output  32  word address of the current read
mem_rdata  input  32  read data, valid one cycle after mem_re
rf_we  output  1  register-file write enable (registers r0-r14 only)
rf_wa  output  4  register-file write address
rf_wd  output  32  register-file / PC write data
pc_we  output  1  load rf_wd into PC (r15 target)
done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, mem_re, rf_we, pc_we and done are 0.
  - mem_addr, rf_wa and rf_wd are 0.
  - Reset mid-operation abandons the transfer; no further writes occur.
- States: IDLE, SETUP, XFER, LAST, BASEWB.
- IDLE:
  - busy = start, combinational, so the pipeline stalls in the request cycle.
  - If start is 1: latch all inputs and go to SETUP.
  - start in any other state is ignored.
- SETUP (1 cycle):
  - N = popcount(reglist).
  - First address A0:
    - IA: base
    - IB: base+4
    - DA: base-4N+4
    - DB: base-4N
  - Writeback value: up ? base+4N : base-4N, mod 2^32.
  - If N = 0: no reads and no writes; done pulses in this cycle; return to IDLE.
  - Otherwise go to XFER.
- XFER:
  - Each cycle assert mem_re with mem_addr = A0+4k for the k-th selected register.
  - Clear that bit from the working list.
  - After issuing the last read, go to LAST.
- Write stream:
  - In the cycle after each read, drive rf_wd = mem_rdata.
  - Drive rf_wa with the index of the register the read was issued for.
  - Index 0-14: rf_we = 1, pc_we = 0.
  - Index 15: rf_we = 0, pc_we = 1.
  - Reads and writes overlap, so N registers complete N cycles after the first read.
- LAST:
  - Performs the final write.
  - If wback = 1 and reglist[rn] = 0: go to BASEWB.
  - Otherwise: done = 1 in this cycle; go to IDLE.
- BASEWB:
  - rf_we = 1, rf_wa = rn, rf_wd = writeback value.
  - done = 1; go to IDLE.
- Base conflict: if rn is in reglist, the loaded value wins and the base writeback is suppressed.
- Busy: high from the start cycle through the done cycle inclusive; low the cycle after done.
- Latency: start at cycle 0 → first mem_re at cycle 2 → last write at cycle N+2. Base writeback, when performed, is at cycle N+3.
- Back-to-back: start in the cycle after done is accepted.
- Address arithmetic wraps mod 2^32 with no fault.

Test Plan:
1. IA, reglist=0x0006, base=0x100, rn=0, wback=1; memory returns 0xA1 at 0x100 and 0xB2 at 0x104:
   - mem_re at cycles 2 and 3.
   - Writes r1=0xA1 at cycle 3 and r2=0xB2 at cycle 4.
   - r0 written with 0x108 at cycle 5.
   - done pulses at cycle 5; busy is high for cycles 0-5.
2. DB, reglist=0x8001, base=0x200, wback=0:
   - Reads from 0x1F8, then 0x1FC.
   - r0 is written via rf_we; r15 is loaded via pc_we=1 with rf_we=0.
   - No base write.
3. reglist=0x0000, start at cycle 0:
   - done at cycle 1.
   - mem_re, rf_we and pc_we never asserted.
4. IA, rn=3, reglist=0x0008, wback=1, base=0x40:
   - r3 receives the memory data from 0x40.
   - No BASEWB cycle occurs.
5. reset asserted at cycle 3 of a 4-register LDM:
   - All outputs are 0 the next cycle.
   - No further rf_we or pc_we.
   - A new start is accepted.
6. start held high during busy, then a second start in the cycle after done:
   - Exactly two transfers occur.
   - The second transfer's first mem_re comes 2 cycles after its start.
